// File: rtl/matmul_result_checker.sv
// On-chip result checker for the matmul accelerator: snapshots the scratchpad result
// bus on start, compares it row-major against an expected stream, reports errors.
module matmul_result_checker #(
  parameter int BUS_WIDTH  = 32,
  parameter int MAX_DIM    = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int TEST_CNT_W = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic [$clog2(MAX_DIM):0]             rows_i,
  input  logic [$clog2(MAX_DIM):0]             cols_i,
  input  logic                                 signed_i,
  input  logic [BUS_WIDTH-1:0]                 tol_i,
  input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] data_sp_i,
  input  logic                                 exp_valid_i,
  input  logic [BUS_WIDTH-1:0]                 exp_data_i,
  output logic                                 exp_ready_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 dim_err_o,
  output logic [ERR_CNT_W-1:0]                 err_cnt_o,
  output logic                                 first_err_vld_o,
  output logic [$clog2(MAX_DIM)-1:0]           first_err_row_o,
  output logic [$clog2(MAX_DIM)-1:0]           first_err_col_o,
  output logic [BUS_WIDTH-1:0]                 first_err_exp_o,
  output logic [BUS_WIDTH-1:0]                 first_err_got_o,
  output logic [TEST_CNT_W-1:0]                test_num_o
);
  localparam int IDX_W = $clog2(MAX_DIM);
  localparam int DIM_W = IDX_W + 1;
  localparam int NEL   = MAX_DIM * MAX_DIM;
  localparam int EL_W  = $clog2(NEL);
  localparam int XW    = BUS_WIDTH + 2;
  localparam int DW    = BUS_WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [1:0]                    state_q, state_d;
  logic [NEL-1:0][BUS_WIDTH-1:0] snap_q, snap_d;
  logic [DIM_W-1:0]              rows_q, rows_d, cols_q, cols_d;
  logic                          sgn_q, sgn_d;
  logic [BUS_WIDTH-1:0]          tol_q, tol_d;
  logic [IDX_W-1:0]              row_q, row_d, col_q, col_d;
  logic [ERR_CNT_W-1:0]          err_q, err_d;
  logic                          pass_q, pass_d, dim_err_q, dim_err_d, fv_q, fv_d;
  logic [IDX_W-1:0]              frow_q, frow_d, fcol_q, fcol_d;
  logic [BUS_WIDTH-1:0]          fexp_q, fexp_d, fgot_q, fgot_d;
  logic [TEST_CNT_W-1:0]         tnum_q, tnum_d;

  logic [EL_W-1:0]      el_idx;
  logic [BUS_WIDTH-1:0] got;
  logic [XW-1:0]        got_x, exp_x, sub_x;
  logic [DW-1:0]        diff;
  logic                 mism, col_last, row_last, dims_ok;

  assign el_idx = EL_W'(row_q) * EL_W'(MAX_DIM) + EL_W'(col_q);
  assign got    = snap_q[el_idx];

  // Two guard bits keep the difference exact for both signed and unsigned operands.
  assign got_x = sgn_q ? {{2{got[BUS_WIDTH-1]}}, got} : {2'b00, got};
  assign exp_x = sgn_q ? {{2{exp_data_i[BUS_WIDTH-1]}}, exp_data_i} : {2'b00, exp_data_i};
  assign sub_x = got_x - exp_x;
  assign diff  = sub_x[XW-1] ? DW'(-sub_x) : DW'(sub_x);
  assign mism  = diff > {1'b0, tol_q};

  assign col_last = ({1'b0, col_q} == cols_q - DIM_W'(1));
  assign row_last = ({1'b0, row_q} == rows_q - DIM_W'(1));
  assign dims_ok  = (rows_i != '0) && (rows_i <= DIM_W'(MAX_DIM)) &&
                    (cols_i != '0) && (cols_i <= DIM_W'(MAX_DIM));

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    sgn_d     = sgn_q;
    tol_d     = tol_q;
    row_d     = row_q;
    col_d     = col_q;
    err_d     = err_q;
    pass_d    = pass_q;
    dim_err_d = dim_err_q;
    fv_d      = fv_q;
    frow_d    = frow_q;
    fcol_d    = fcol_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    tnum_d    = tnum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d  = '0;
          fv_d   = 1'b0;
          pass_d = 1'b0;
          row_d  = '0;
          col_d  = '0;
          if (dims_ok) begin
            snap_d    = data_sp_i;
            rows_d    = rows_i;
            cols_d    = cols_i;
            sgn_d     = signed_i;
            tol_d     = tol_i;
            dim_err_d = 1'b0;
            state_d   = S_CMP;
          end else begin
            dim_err_d = 1'b1;
            tnum_d    = tnum_q + TEST_CNT_W'(1);
            state_d   = S_DONE;
          end
        end
      end
      S_CMP: begin
        if (abort_i) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (exp_valid_i) begin
          if (mism) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_CNT_W'(1);
            if (!fv_q) begin
              fv_d   = 1'b1;
              frow_d = row_q;
              fcol_d = col_q;
              fexp_d = exp_data_i;
              fgot_d = got;
            end
          end
          if (col_last) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
          // Results land together with done_o, so pass/test count update on entry to DONE.
          if (col_last && row_last) begin
            pass_d  = (err_q == '0) && !mism;
            tnum_d  = tnum_q + TEST_CNT_W'(1);
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      sgn_q     <= 1'b0;
      tol_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      dim_err_q <= 1'b0;
      fv_q      <= 1'b0;
      frow_q    <= '0;
      fcol_q    <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
      tnum_q    <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      sgn_q     <= sgn_d;
      tol_q     <= tol_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      dim_err_q <= dim_err_d;
      fv_q      <= fv_d;
      frow_q    <= frow_d;
      fcol_q    <= fcol_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
      tnum_q    <= tnum_d;
    end
  end

  assign busy_o          = (state_q == S_CMP);
  assign exp_ready_o     = (state_q == S_CMP);
  assign done_o          = (state_q == S_DONE);
  assign pass_o          = pass_q;
  assign dim_err_o       = dim_err_q;
  assign err_cnt_o       = err_q;
  assign first_err_vld_o = fv_q;
  assign first_err_row_o = frow_q;
  assign first_err_col_o = fcol_q;
  assign first_err_exp_o = fexp_q;
  assign first_err_got_o = fgot_q;
  assign test_num_o      = tnum_q;
endmodule

// File: tb/tb_matmul_result_checker.sv
// Scoreboard bench: driver pushes model results per check, monitor pops on done_o.
// A second instance with a 3-bit error counter shares all inputs to exercise saturation.
module tb_matmul_result_checker;
  localparam int BW = 32;
  localparam int MD = 4;
  localparam int NE = MD * MD;

  typedef struct {
    bit          dim;
    int          err;
    bit          pass;
    bit          fv;
    int          frow;
    int          fcol;
    logic [31:0] fexp;
    logic [31:0] fgot;
    int          tnum;
  } exp_t;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            start_i = 1'b0, abort_i = 1'b0, signed_i = 1'b0;
  logic [2:0]      rows_i = '0, cols_i = '0;
  logic [BW-1:0]   tol_i = '0, exp_data_i = '0;
  logic [BW*NE-1:0] data_sp_i = '0;
  logic            exp_valid_i = 1'b0;

  logic            exp_ready_o, busy_o, done_o, pass_o, dim_err_o, fv_o;
  logic [7:0]      err_cnt_o;
  logic [1:0]      frow_o, fcol_o;
  logic [BW-1:0]   fexp_o, fgot_o;
  logic [15:0]     test_num_o;

  logic            s_ready, s_busy, s_done, s_pass, s_dim_err, s_fv;
  logic [2:0]      s_err_cnt;
  logic [1:0]      s_frow, s_fcol;
  logic [BW-1:0]   s_fexp, s_fgot;
  logic [15:0]     s_test_num;

  int   n_cmp = 0, n_fail = 0, tnum = 0;
  exp_t q[$];
  logic [31:0] sp_m [MD][MD];
  logic [31:0] ex_m [NE];

  matmul_result_checker #(.BUS_WIDTH(BW), .MAX_DIM(MD), .ERR_CNT_W(8), .TEST_CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .rows_i(rows_i), .cols_i(cols_i), .signed_i(signed_i), .tol_i(tol_i),
    .data_sp_i(data_sp_i), .exp_valid_i(exp_valid_i), .exp_data_i(exp_data_i),
    .exp_ready_o(exp_ready_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .dim_err_o(dim_err_o), .err_cnt_o(err_cnt_o), .first_err_vld_o(fv_o),
    .first_err_row_o(frow_o), .first_err_col_o(fcol_o), .first_err_exp_o(fexp_o),
    .first_err_got_o(fgot_o), .test_num_o(test_num_o));

  matmul_result_checker #(.BUS_WIDTH(BW), .MAX_DIM(MD), .ERR_CNT_W(3), .TEST_CNT_W(16)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .rows_i(rows_i), .cols_i(cols_i), .signed_i(signed_i), .tol_i(tol_i),
    .data_sp_i(data_sp_i), .exp_valid_i(exp_valid_i), .exp_data_i(exp_data_i),
    .exp_ready_o(s_ready), .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass),
    .dim_err_o(s_dim_err), .err_cnt_o(s_err_cnt), .first_err_vld_o(s_fv),
    .first_err_row_o(s_frow), .first_err_col_o(s_fcol), .first_err_exp_o(s_fexp),
    .first_err_got_o(s_fgot), .test_num_o(s_test_num));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Reference: walk the result row-major, take |got-exp| over full-width integers.
  function automatic exp_t model(input int r, input int c, input bit s, input logic [31:0] tol);
    exp_t e;
    e = '{dim: 0, err: 0, pass: 0, fv: 0, frow: 0, fcol: 0, fexp: '0, fgot: '0, tnum: 0};
    for (int k = 0; k < r * c; k++) begin
      int i, j;
      longint g, x, d;
      i = k / c;
      j = k % c;
      g = s ? longint'($signed(sp_m[i][j])) : longint'(sp_m[i][j]);
      x = s ? longint'($signed(ex_m[k])) : longint'(ex_m[k]);
      d = (g > x) ? g - x : x - g;
      if (d > longint'(tol)) begin
        if (!e.fv) begin
          e.fv = 1; e.frow = i; e.fcol = j; e.fexp = ex_m[k]; e.fgot = sp_m[i][j];
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  function automatic logic [BW*NE-1:0] pack_sp();
    logic [BW*NE-1:0] f;
    f = '0;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++)
        f[(i*MD+j)*BW +: BW] = sp_m[i][j];
    return f;
  endfunction

  function automatic logic [BW*NE-1:0] rand_bus();
    logic [BW*NE-1:0] f;
    for (int k = 0; k < NE; k++) f[k*BW +: BW] = $urandom;
    return f;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, exp_ready_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_dim_err"}, dim_err_o, 0);
    chk({tag, "_err_cnt"}, err_cnt_o, 0);
    chk({tag, "_first_vld"}, fv_o, 0);
    chk({tag, "_first_fields"}, {frow_o, fcol_o, fexp_o, fgot_o}, 0);
    chk({tag, "_test_num"}, test_num_o, 0);
  endtask

  task automatic start_chk(input int r, input int c, input bit s, input logic [31:0] tol);
    @(negedge clk);
    start_i = 1'b1; rows_i = 3'(r); cols_i = 3'(c); signed_i = s; tol_i = tol;
    data_sp_i = pack_sp();
  endtask

  // gap: 0 = always valid, 1 = valid pattern 1,0,0,1, 2 = random
  task automatic run(input int r, input int c, input bit s, input logic [31:0] tol,
                     input int gap, input bit chg);
    exp_t e;
    int k, cyc;
    bit v, hs, legal;
    legal = (r >= 1 && r <= MD && c >= 1 && c <= MD);
    start_chk(r, c, s, tol);
    if (legal) e = model(r, c, s, tol);
    else e = '{dim: 1, err: 0, pass: 0, fv: 0, frow: 0, fcol: 0, fexp: '0, fgot: '0, tnum: 0};
    tnum++;
    e.tnum = tnum & 16'hFFFF;
    q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    if (!legal) begin
      chk("dim_done_latency", done_o, 1);
      chk("dim_no_ready", exp_ready_o, 0);
      @(negedge clk);
      chk("dim_no_ready_after", exp_ready_o, 0);
      return;
    end
    if (chg) data_sp_i = rand_bus();
    k = 0; cyc = 0;
    while (k < r * c && cyc < 400) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = $urandom_range(0, 1) == 1;
      endcase
      exp_valid_i = v;
      exp_data_i  = v ? ex_m[k] : $urandom;
      hs = v && exp_ready_o;
      @(negedge clk);
      cyc++;
      if (hs) k++;
    end
    exp_valid_i = 1'b0;
    if (k < r * c) chk("handshake_timeout", k, r * c);
    else chk("done_latency", done_o, 1);
    @(negedge clk);
  endtask

  task automatic fill_rand(input int mode);
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++)
        sp_m[i][j] = (mode == 0) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
    for (int k = 0; k < NE; k++) ex_m[k] = $urandom;
  endtask

  // Expected stream equal to the SP contents for an r x c result.
  task automatic match_exp(input int c);
    for (int k = 0; k < NE; k++) ex_m[k] = sp_m[k / c][k % c];
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done_o) begin
        if (q.size() == 0) begin
          chk("unexpected_done", done_o, 0);
        end else begin
          e = q.pop_front();
          chk("busy_in_done", busy_o, 0);
          chk("dim_err", dim_err_o, e.dim);
          chk("err_cnt", err_cnt_o, (e.err > 255) ? 255 : e.err);
          chk("pass", pass_o, e.pass);
          chk("first_vld", fv_o, e.fv);
          if (e.fv) begin
            chk("first_row", frow_o, e.frow);
            chk("first_col", fcol_o, e.fcol);
            chk("first_exp", fexp_o, e.fexp);
            chk("first_got", fgot_o, e.fgot);
          end
          chk("test_num", test_num_o, e.tnum);
          chk("sat_err_cnt", s_err_cnt, (e.err > 7) ? 7 : e.err);
          chk("sat_pass", s_pass, e.pass);
          chk("sat_test_num", s_test_num, e.tnum);
        end
      end
    end
  end

  initial begin : driver
    int k;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 identity
    sp_m[0][0] = 1; sp_m[0][1] = 0; sp_m[1][0] = 0; sp_m[1][1] = 1;
    match_exp(2);
    run(2, 2, 1, 0, 0, 0);

    // 4x4 with two signed mismatches, then within tolerance
    fill_rand(1);
    sp_m[2][3] = -32'sd5; sp_m[3][0] = 32'd7;
    match_exp(4);
    ex_m[11] = -32'sd4; ex_m[12] = 32'd9;
    run(4, 4, 1, 0, 0, 0);
    run(4, 4, 1, 2, 0, 0);

    // unsigned wide diff, then the same in signed mode
    sp_m[0][0] = 32'hFFFF_FFFF; ex_m[0] = 32'h1;
    run(1, 1, 0, 1, 0, 0);
    run(1, 1, 1, 1, 0, 0);

    // 3x2 with gaps, SP scrambled after start
    fill_rand(0);
    match_exp(2);
    ex_m[3] = ex_m[3] + 32'd100;
    run(3, 2, 0, 0, 1, 1);

    // illegal dims
    run(0, 2, 0, 0, 0, 0);
    run(5, 3, 0, 0, 0, 0);
    run(2, 0, 1, 0, 0, 0);

    // abort after 3 of 16; the aborted 4th element is a mismatch that must not count
    fill_rand(0);
    match_exp(4);
    ex_m[1] = ex_m[1] ^ 32'h10;
    ex_m[3] = ex_m[3] ^ 32'h20;
    start_chk(4, 4, 0, 0);
    @(negedge clk);
    start_i = 1'b0;
    for (k = 0; k < 3; k++) begin
      exp_valid_i = 1'b1; exp_data_i = ex_m[k];
      @(negedge clk);
    end
    abort_i = 1'b1; exp_valid_i = 1'b1; exp_data_i = ex_m[3];
    @(negedge clk);
    abort_i = 1'b0; exp_valid_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_test_num", test_num_o, tnum);
    chk("abort_pass", pass_o, 0);
    chk("abort_err_cnt", err_cnt_o, 1);
    chk("abort_first_col", {fv_o, fcol_o}, {1'b1, 2'd1});
    repeat (3) @(negedge clk);
    run(4, 4, 0, 0, 2, 0);

    // every element mismatches: wide counter 16, narrow counter pinned at 7
    fill_rand(0);
    for (k = 0; k < NE; k++) ex_m[k] = ~sp_m[k / MD][k % MD];
    run(4, 4, 0, 0, 0, 0);

    // randomized checks
    for (int it = 0; it < 30; it++) begin
      int r, c;
      r = $urandom_range(0, 9) == 0 ? $urandom_range(0, 5) : $urandom_range(1, 4);
      c = $urandom_range(1, 4);
      fill_rand($urandom_range(0, 1));
      match_exp(c);
      for (k = 0; k < NE; k++)
        if ($urandom_range(0, 2) == 0) ex_m[k] = ex_m[k] + 32'($urandom_range(0, 8)) - 32'd4;
      run(r, c, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), 2, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a check
    fill_rand(0);
    match_exp(4);
    ex_m[0] = ~ex_m[0];
    start_chk(4, 4, 1, 0);
    @(negedge clk);
    start_i = 1'b0;
    for (k = 0; k < 2; k++) begin
      exp_valid_i = 1'b1; exp_data_i = ex_m[k];
      @(negedge clk);
    end
    exp_valid_i = 1'b0;
    chk("pre_reset_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    tnum = 0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand(1);
    match_exp(3);
    run(2, 3, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
